// File: rtl/hs_ifr_misc_typedefs_pkg.sv
// hs_ifr_misc_typedefs_pkg: small shared enums used across the hs_unit blocks
package hs_ifr_misc_typedefs_pkg;
    typedef enum logic [1:0] {
        EDGE_POSEDGE = 2'd0,
        EDGE_NEGEDGE = 2'd1,
        EDGE_BOTH    = 2'd2
    } edge_e;
endpackage

// File: rtl/hs_unit_rr_pick.sv
// hs_unit_rr_pick: first set request at or above ptr, wrapping modulo N
module hs_unit_rr_pick #(
    parameter  int N    = 4,
    localparam int ID_W = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    output logic            found,
    output logic [ID_W-1:0] idx
);
    // scan from the farthest offset down so the nearest hit is written last
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[(int'(ptr) + i) % N]) begin
                found = 1'b1;
                idx   = ID_W'((int'(ptr) + i) % N);
            end
        end
    end
endmodule

// File: rtl/hs_unit_sedge_det.sv
// hs_unit_sedge_det: edge detector on a clk-synchronous signal, combinational output
module hs_unit_sedge_det
    import hs_ifr_misc_typedefs_pkg::*;
#(
    parameter edge_e EDGE = EDGE_POSEDGE
) (
    input  logic clk,
    input  logic aresetn,
    input  logic sig,
    output logic edge_det
);
    logic sig_d;

    // delay register resets low so a line held high through reset shows a rising edge
    always_ff @(posedge clk or negedge aresetn)
        if (!aresetn) sig_d <= 1'b0;
        else          sig_d <= sig;

    assign edge_det = (EDGE == EDGE_POSEDGE) ? (sig & ~sig_d) :
                      (EDGE == EDGE_NEGEDGE) ? (~sig & sig_d) : (sig ^ sig_d);
endmodule

// File: rtl/hs_unit_edge_evt_arb.sv
// hs_unit_edge_evt_arb: per-channel edge events queued in saturating counters,
// served one at a time round-robin through a registered valid/ready slot
module hs_unit_edge_evt_arb
    import hs_ifr_misc_typedefs_pkg::*;
#(
    parameter  int    N_CH  = 4,
    parameter  edge_e EDGE  = EDGE_POSEDGE,
    parameter  int    CNT_W = 2,
    localparam int    ID_W  = $clog2(N_CH)
) (
    input  logic            clk,
    input  logic            aresetn,
    input  logic [N_CH-1:0] sig_in,
    input  logic [N_CH-1:0] ch_en,
    output logic            evt_valid,
    input  logic            evt_ready,
    output logic [ID_W-1:0] evt_id,
    output logic [N_CH-1:0] ovf_sticky,
    input  logic            ovf_clr
);
    localparam logic [CNT_W-1:0] PEND_MAX = '1;

    logic [N_CH-1:0]            edge_det, inc, dec, req, ovf_set;
    logic [N_CH-1:0][CNT_W-1:0] pend;
    logic [ID_W-1:0]            rr_ptr, win;
    logic                       found, load_ok, grant;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        hs_unit_sedge_det #(.EDGE(EDGE)) u_det (
            .clk      (clk),
            .aresetn  (aresetn),
            .sig      (sig_in[i]),
            .edge_det (edge_det[i])
        );
        assign req[i]     = |pend[i];
        assign dec[i]     = grant && (win == ID_W'(i));
        assign ovf_set[i] = inc[i] & ~dec[i] & (pend[i] == PEND_MAX);
    end

    assign inc     = edge_det & ch_en;
    assign load_ok = ~evt_valid | evt_ready;
    assign grant   = load_ok & found;

    hs_unit_rr_pick #(.N(N_CH)) u_pick (
        .req   (req),
        .ptr   (rr_ptr),
        .found (found),
        .idx   (win)
    );

    always_ff @(posedge clk or negedge aresetn)
        if (!aresetn) begin
            evt_valid <= 1'b0;
            evt_id    <= '0;
            rr_ptr    <= '0;
        end else if (load_ok) begin
            evt_valid <= found;
            if (found) begin
                evt_id <= win;
                rr_ptr <= (win == ID_W'(N_CH - 1)) ? '0 : win + 1'b1;
            end
        end

    // a grant coincident with a new edge leaves the count untouched
    always_ff @(posedge clk or negedge aresetn)
        if (!aresetn) pend <= '0;
        else
            for (int c = 0; c < N_CH; c++)
                if (inc[c] & ~dec[c] & (pend[c] != PEND_MAX)) pend[c] <= pend[c] + 1'b1;
                else if (dec[c] & ~inc[c])                    pend[c] <= pend[c] - 1'b1;

    always_ff @(posedge clk or negedge aresetn)
        if (!aresetn) ovf_sticky <= '0;
        else          ovf_sticky <= (ovf_clr ? '0 : ovf_sticky) | ovf_set;
endmodule

// File: tb/tb_hs_unit_edge_evt_arb.sv
// tb_hs_unit_edge_evt_arb: directed plus random stimulus against an abstract queue/scan model
module tb_hs_unit_edge_evt_arb;
    import hs_ifr_misc_typedefs_pkg::*;

    localparam int N    = 4;
    localparam int PMAX = 3;

    logic         clk = 1'b0, aresetn = 1'b1, evt_ready = 1'b0, ovf_clr = 1'b0;
    logic [N-1:0] sig_in = '0, ch_en = '1;
    logic         evt_valid, evt_valid_b;
    logic [1:0]   evt_id, evt_id_b;
    logic [N-1:0] ovf_sticky, ovf_sticky_b;

    int n_assert = 0, fails = 0;
    int pend_m[2][N];
    bit vld_m[2];
    int id_m[2], rr_m[2];
    bit [N-1:0] ovf_m[2], prev_m[2];
    int hs[2];
    int last_id = -1;
    int h0, h1;

    always #5 clk = ~clk;

    hs_unit_edge_evt_arb #(.N_CH(N), .EDGE(EDGE_POSEDGE), .CNT_W(2)) dut_p (
        .clk(clk), .aresetn(aresetn), .sig_in(sig_in), .ch_en(ch_en),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_id(evt_id),
        .ovf_sticky(ovf_sticky), .ovf_clr(ovf_clr)
    );

    hs_unit_edge_evt_arb #(.N_CH(N), .EDGE(EDGE_BOTH), .CNT_W(2)) dut_b (
        .clk(clk), .aresetn(aresetn), .sig_in(sig_in), .ch_en(ch_en),
        .evt_valid(evt_valid_b), .evt_ready(evt_ready), .evt_id(evt_id_b),
        .ovf_sticky(ovf_sticky_b), .ovf_clr(ovf_clr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < N; i++) pend_m[m][i] = 0;
            vld_m[m] = 0; id_m[m] = 0; rr_m[m] = 0; ovf_m[m] = '0; prev_m[m] = '0;
        end
    endtask

    // one clock of the abstract model: edges add to per-channel queues, a modulo scan picks the next
    task automatic model_step(input int m);
        bit [N-1:0] e, inc;
        bit f;
        int w, c;
        e   = (m == 0) ? (sig_in & ~prev_m[m]) : (sig_in ^ prev_m[m]);
        inc = e & ch_en;
        f = 0; w = 0;
        if (!vld_m[m] || evt_ready) begin
            for (int k = 0; k < N; k++) begin
                c = (rr_m[m] + k) % N;
                if (!f && pend_m[m][c] > 0) begin f = 1; w = c; end
            end
            vld_m[m] = f;
            if (f) begin id_m[m] = w; rr_m[m] = (w + 1) % N; end
        end
        if (ovf_clr) ovf_m[m] = '0;
        for (int i = 0; i < N; i++) begin
            if (inc[i] && !(f && w == i)) begin
                if (pend_m[m][i] == PMAX) ovf_m[m][i] = 1'b1;
                else pend_m[m][i]++;
            end else if (f && w == i && !inc[i]) pend_m[m][i]--;
        end
        prev_m[m] = sig_in;
    endtask

    task automatic tick();
        if (evt_valid && evt_ready) begin hs[0]++; last_id = int'(evt_id); end
        if (evt_valid_b && evt_ready) hs[1]++;
        model_step(0);
        model_step(1);
        @(posedge clk);
        #1;
        chk("valid_p", 32'(evt_valid), 32'(vld_m[0]));
        chk("id_p", 32'(evt_id), id_m[0]);
        chk("ovf_p", 32'(ovf_sticky), 32'(ovf_m[0]));
        chk("valid_b", 32'(evt_valid_b), 32'(vld_m[1]));
        chk("id_b", 32'(evt_id_b), id_m[1]);
        chk("ovf_b", 32'(ovf_sticky_b), 32'(ovf_m[1]));
    endtask

    task automatic do_reset(input logic [N-1:0] s);
        aresetn = 1'b0;
        #1;
        model_reset();
        chk("rst_valid", 32'(evt_valid), 0);
        chk("rst_id", 32'(evt_id), 0);
        chk("rst_ovf", 32'(ovf_sticky), 0);
        chk("rst_valid_b", 32'(evt_valid_b), 0);
        sig_in = s;
        repeat (2) @(posedge clk);
        #1;
        aresetn = 1'b1;
    endtask

    task automatic pulse(input logic [N-1:0] mask);
        sig_in = mask;
        tick();
        sig_in = '0;
        tick();
    endtask

    initial begin
        hs[0] = 0; hs[1] = 0;
        do_reset('0);

        // single pulse held three cycles gives one event, one cycle after the edge
        evt_ready = 1'b1;
        sig_in = 4'b0100;
        tick();
        chk("t1_pend_only", 32'(evt_valid), 0);
        tick();
        chk("t1_valid", 32'(evt_valid), 1);
        chk("t1_id", 32'(evt_id), 2);
        tick();
        chk("t1_drop", 32'(evt_valid), 0);
        sig_in = '0;
        tick();
        chk("t1_idle", 32'(evt_valid), 0);

        // simultaneous edges are served in rotating order from the pointer
        do_reset('0);
        evt_ready = 1'b1;
        sig_in = 4'hF;
        tick();
        sig_in = '0;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("t2_valid", 32'(evt_valid), 1);
            chk("t2_id", 32'(evt_id), k);
        end
        tick();
        chk("t2_end", 32'(evt_valid), 0);
        pulse(4'b0010);
        tick();
        sig_in = 4'hF;
        tick();
        sig_in = '0;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("t2b_id", 32'(evt_id), (k + 2) % 4);
        end

        // saturation while the consumer stalls, then drain
        do_reset('0);
        evt_ready = 1'b0;
        repeat (5) pulse(4'b0010);
        chk("t3_ovf", 32'(ovf_sticky), 32'h2);
        chk("t3_valid", 32'(evt_valid), 1);
        chk("t3_id", 32'(evt_id), 1);
        h0 = hs[0];
        evt_ready = 1'b1;
        repeat (8) tick();
        chk("t3_events", hs[0] - h0, 4);

        // edge coincident with a grant at saturation: no overflow, count held
        evt_ready = 1'b0;
        repeat (4) pulse(4'b0010);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("t4_clr", 32'(ovf_sticky), 0);
        sig_in = 4'b0010;
        evt_ready = 1'b1;
        tick();
        sig_in = '0;
        chk("t4_no_ovf", 32'(ovf_sticky), 0);
        h0 = hs[0];
        repeat (8) tick();
        chk("t4_events", hs[0] - h0, 4);

        // clear and a fresh overflow in the same cycle: the set wins
        do_reset('0);
        evt_ready = 1'b0;
        repeat (5) pulse(4'b1000);
        chk("t4_ovf3", 32'(ovf_sticky), 32'h8);
        repeat (3) pulse(4'b0001);
        sig_in = 4'b0001;
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        sig_in = '0;
        chk("t4_set_wins", 32'(ovf_sticky), 32'h1);
        tick();

        // masked channel produces nothing; masking later keeps queued events
        do_reset('0);
        evt_ready = 1'b1;
        ch_en = 4'b0111;
        h0 = hs[0];
        repeat (4) pulse(4'b1000);
        chk("t5_masked", hs[0] - h0, 0);
        chk("t5_masked_v", 32'(evt_valid), 0);
        ch_en = '1;
        evt_ready = 1'b0;
        repeat (3) pulse(4'b1000);
        ch_en = 4'b0111;
        evt_ready = 1'b1;
        h0 = hs[0];
        repeat (6) tick();
        chk("t5_kept", hs[0] - h0, 3);
        chk("t5_kept_id", last_id, 3);
        ch_en = '1;

        // both-edge instance sees two events for one high pulse
        do_reset('0);
        evt_ready = 1'b1;
        h0 = hs[0];
        h1 = hs[1];
        pulse(4'b0001);
        repeat (5) tick();
        chk("t5_pos_events", hs[0] - h0, 1);
        chk("t5_both_events", hs[1] - h1, 2);

        // reset mid-stream drops everything; a line held high through release yields one event
        do_reset('0);
        evt_ready = 1'b0;
        repeat (3) pulse(4'b0001);
        chk("t6_pre_valid", 32'(evt_valid), 1);
        do_reset(4'b0001);
        evt_ready = 1'b1;
        h0 = hs[0];
        last_id = -1;
        repeat (5) tick();
        chk("t6_events", hs[0] - h0, 1);
        chk("t6_id", last_id, 0);
        sig_in = '0;

        // random traffic against the model, with one reset partway through
        do_reset('0);
        for (int n = 0; n < 400; n++) begin
            if (n == 200) do_reset(4'($urandom));
            sig_in    = 4'($urandom);
            ch_en     = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
            evt_ready = ($urandom_range(0, 3) != 0);
            ovf_clr   = ($urandom_range(0, 15) == 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, fails);
        $finish;
    end
endmodule

// File: doc/hs_unit_edge_evt_arb.md
Name: hs_unit_edge_evt_arb

Overview:
Multi-channel synchronized edge-event collector and round-robin scheduler. Each of N_CH input signals passes through a per-channel synchronized edge detector. Detected edges are queued in a per-channel saturating pending counter. A single valid/ready event port serves the pending events one at a time in round-robin order. The block sits between raw status/interrupt-like lines and a single event consumer, such as an interrupt controller or sequencer.

Parameters:
N_CH, 4, number of input channels (2..32)
EDGE, hs_ifr_misc_typedefs_pkg::EDGE_POSEDGE, edge type detected on every channel (edge_e)
CNT_W, 2, pending counter width per channel; saturates at 2^CNT_W-1
ID_W, $clog2(N_CH), localparam, width of channel index

Ports:
clk  input  1  clock; all logic is on its rising edge
aresetn  input  1  asynchronous active-low reset
sig_in  input  N_CH  per-channel signals, already synchronous to clk
ch_en  input  N_CH  per-channel enable; a 0 masks new edges on that channel
evt_valid  output  1  event available
evt_ready  input  1  consumer accepts event
evt_id  output  ID_W  channel index of the presented event
ovf_sticky  output  N_CH  per-channel sticky overflow flag
ovf_clr  input  1  one-cycle pulse that clears all ovf_sticky bits

Behaviour:
- Reset (aresetn=0, asynchronous):
  - evt_valid=0, evt_id=0, ovf_sticky=0.
  - All pending counters=0, rr_ptr=0, edge-detector delay registers=0.
  - Consequence: a channel held high across reset release reports one posedge (POSEDGE/BOTH).
- Edge detect: edge_det[i] is combinational from sig_in[i] and its 1-cycle delayed copy, per EDGE. It is qualified by ch_en[i] in the same cycle.
- Pending counter pend[i] update at each clock edge:
  - inc = edge_det[i] & ch_en[i]; dec = channel i granted this cycle.
  - inc & ~dec: pend+1 if not saturated. If saturated, pend holds and ovf_sticky[i] is set.
  - dec & ~inc: pend-1.
  - inc & dec: pend unchanged and no overflow, even at saturation.
  - Clearing ch_en does not flush existing pending counts; they are still served.
- Output stage: a single registered slot (evt_valid/evt_id).
  - load_ok = ~evt_valid | evt_ready.
  - When load_ok, select the first channel with pend>0, searching from rr_ptr upward with modulo-N_CH wrap.
  - If a channel is found: evt_valid<=1, evt_id<=winner, dec that channel, rr_ptr<=(winner+1) mod N_CH.
  - If no channel is found: evt_valid<=0 when evt_ready, otherwise hold. evt_id holds its last value.
  - While evt_valid & ~evt_ready, evt_valid and evt_id are stable and no grant occurs.
- Throughput: one event per cycle under continuous evt_ready. No bubble between back-to-back events.
- Latency: sig_in first sampled high at clock edge k (idle slot, posedge mode) gives pend=1 after edge k and evt_valid=1 after edge k+1. There is no combinational path from sig_in to the outputs.
- Pending counts only edges that occurred before the grant decision; an edge in the grant cycle follows the inc&dec rule.
- ovf_clr: clears all ovf_sticky at the next edge. If an overflow occurs in the same cycle, set wins for that channel.
- evt_ready while evt_valid=0 is ignored.
- Reset asserted mid-transaction drops all pending and presented events. No event is replayed after reset.

Decomposition:
- edge_e comes from hs_ifr_misc_typedefs_pkg; no new package types are needed.
- The saturation max, (1<<CNT_W)-1, is a local constant.
- Instantiate the existing synchronized edge detector hs_unit_sedge_det once per channel (generate loop), passing EDGE.
- One new combinational sub-module, hs_unit_rr_pick:
  - Parameter N.
  - Inputs: req[N], ptr[ID_W].
  - Outputs: found, idx[ID_W] (rotate-priority first-set finder).
  - Reusable by other arbiters.

Test Plan:
1. N_CH=4, evt_ready=1, pulse sig_in[2] high for 3 cycles at edge k -> evt_valid=1 with evt_id=2 for exactly cycle k+1, then 0; pend[2]=0.
2. Edges on ch0..3 in the same cycle, evt_ready=1 -> evt_id sequence 0,1,2,3 on consecutive cycles; rr_ptr=0 afterwards. Repeat with rr_ptr=2 -> sequence 2,3,0,1.
3. evt_ready=0, five separate edges on ch1 (CNT_W=2) -> pend[1] saturates at 3, ovf_sticky[1]=1, evt_valid=1 with evt_id=1 stable throughout. Then evt_ready=1 -> exactly 4 events with id 1 (1 presented + 3 pending).
4. With ch1 saturated, an edge on ch1 coincident with a ch1 grant -> pend[1] stays 3 and ovf_sticky unchanged. Pulse ovf_clr together with a new overflow on ch0 and an existing flag on ch3 -> ovf_sticky[0]=1, ovf_sticky[3]=0.
5. ch_en[3]=0, toggle sig_in[3] -> no events. Set ch_en[3]=0 while pend[3]=2 -> 2 events with id 3 still delivered. EDGE=EDGE_BOTH, one high pulse -> 2 events.
6. Assert aresetn=0 mid-stream with evt_valid=1 and pend=2 -> all outputs 0 immediately. After release, with sig_in[0] held high (posedge mode) -> one event with id 0.
